// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and defaults for the display scanner
package disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DEF_DIGITS = 4;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_DIV    = 1000;

    // Value the segment decoder renders as an all-dark digit
    localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/disp_tick.sv
// rtl/disp_tick.sv - DIV-cycle prescaler producing one tick per digit slot
module disp_tick #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - double-buffered multiplexed digit scanner (DISP_SCAN_LZ_EN: leading-zero suppression)
module disp_scan
    import disp_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIV    = DEF_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] data_in,
    input  logic [DIGITS-1:0]       blank_mask,
    output logic [WIDTH-1:0]        digit_out,
    output logic [DIGITS-1:0]       digit_sel,
    output logic                    blank_out,
    output logic                    frame_done
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t                  state, state_next;
    logic [IW-1:0]           index;
    logic [DIGITS*WIDTH-1:0] shadow, active;
    logic                    pending;
    logic                    run, tick, wrap, boundary;
    logic [DIGITS-1:0]       lz;
    logic [WIDTH-1:0]        cur_digit;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = SCAN;
            SCAN:    if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign run = (state == SCAN) && enable;

    disp_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (!run),
        .tick  (tick)
    );

    assign wrap = tick && (index == LAST_IDX);
    // Entering SCAN counts as a frame boundary so a pending load shows in the first slot
    assign boundary = wrap || ((state == IDLE) && enable);

`ifdef DISP_SCAN_LZ_EN
    logic zero_above;
    always_comb begin
        zero_above = 1'b1;
        lz = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (active[i*WIDTH +: WIDTH] == '0);
            lz[i] = zero_above;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        cur_digit = active[int'(index)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            index      <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            digit_out  <= '0;
            digit_sel  <= '0;
            blank_out  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state <= state_next;

            if (!run) begin
                index <= '0;
            end else if (tick) begin
                index <= wrap ? '0 : index + IW'(1);
            end

            if (load) begin
                shadow <= data_in;
            end
            if (boundary) begin
                if (load) begin
                    active <= data_in;
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            if (run) begin
                digit_out  <= cur_digit;
                digit_sel  <= DIGITS'(1) << index;
                blank_out  <= blank_mask[index] | lz[index];
                frame_done <= wrap;
            end else begin
                digit_out  <= '0;
                digit_sel  <= '0;
                blank_out  <= 1'b1;
                frame_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - scoreboard bench for disp_scan with DIGITS=4, WIDTH=4, DIV=3
module tb_disp_scan;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 4;
    localparam int DIV    = 3;
`ifdef DISP_SCAN_LZ_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_mask;
    logic [3:0]  digit_out;
    logic [3:0]  digit_sel;
    logic        blank_out;
    logic        frame_done;

    int tests  = 0;
    int failed = 0;

    // Entry layout: {digit_sel, digit_out, blank_out, frame_done}
    logic [9:0] expq[$];
    logic [9:0] exp_v;

    disp_scan #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .blank_mask (blank_mask),
        .digit_out  (digit_out),
        .digit_sel  (digit_sel),
        .blank_out  (blank_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {digit_sel, digit_out, blank_out, frame_done};
    endfunction

    task automatic push_idle(input int n);
        repeat (n) expq.push_back({4'b0000, 4'h0, 1'b1, 1'b0});
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] m);
        for (int i = 0; i < DIGITS; i++) begin
            logic [3:0] v;
            logic       z;
            logic       b;
            v = d[i*4 +: 4];
            z = LZ && (i > 0) && ((d >> (i*4)) == 16'h0000);
            b = m[i] | z;
            for (int c = 0; c < DIV; c++)
                expq.push_back({4'(1 << i), v, b, 1'((i == DIGITS-1) && (c == DIV-1))});
        end
    endtask

    task automatic test_reset();
        int i;
        rst = 1'b1; enable = 1'b0; load = 1'b0; data_in = '0; blank_mask = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_idle(10);
        i = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            exp_v = expq.pop_front(); tests++;
            if (obs() !== exp_v) begin
                failed++;
                $display("FAIL reset cyc=%0d got=%b want=%b", i, obs(), exp_v);
            end
            i++;
        end
    endtask

    task automatic test_scan();
        int i;
        data_in = 16'h4321; load = 1'b1; enable = 1'b1;
        push_idle(1);
        push_frame(16'h4321, 4'b0000);
        push_frame(16'h4321, 4'b0000);
        i = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            exp_v = expq.pop_front(); tests++;
            if (obs() !== exp_v) begin
                failed++;
                $display("FAIL scan cyc=%0d got=%b want=%b", i, obs(), exp_v);
            end
            if (i == 0) load = 1'b0;
            i++;
        end
    endtask

    task automatic test_midframe();
        int i;
        push_frame(16'h4321, 4'b0000);
        push_frame(16'h8765, 4'b0000);
        i = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            exp_v = expq.pop_front(); tests++;
            if (obs() !== exp_v) begin
                failed++;
                $display("FAIL midframe cyc=%0d got=%b want=%b", i, obs(), exp_v);
            end
            if (i == 4) begin load = 1'b1; data_in = 16'h8765; end
            if (i == 5) load = 1'b0;
            i++;
        end
    endtask

    task automatic test_lz();
        int i;
        push_frame(16'h8765, 4'b0000);
        push_frame(16'h0005, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        i = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            exp_v = expq.pop_front(); tests++;
            if (obs() !== exp_v) begin
                failed++;
                $display("FAIL lz cyc=%0d got=%b want=%b", i, obs(), exp_v);
            end
            if (i == 1)  begin load = 1'b1; data_in = 16'h9999; end
            if (i == 5)  begin load = 1'b1; data_in = 16'h0005; end
            if (i == 13) begin load = 1'b1; data_in = 16'h0000; end
            if (i == 2 || i == 6 || i == 14) load = 1'b0;
            i++;
        end
    endtask

    task automatic test_blank_mask();
        int i;
        blank_mask = 4'b0100;
        push_frame(16'h0000, 4'b0100);
        push_frame(16'h4321, 4'b0100);
        i = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            exp_v = expq.pop_front(); tests++;
            if (obs() !== exp_v) begin
                failed++;
                $display("FAIL blank_mask cyc=%0d got=%b want=%b", i, obs(), exp_v);
            end
            if (i == 1) begin load = 1'b1; data_in = 16'h4321; end
            if (i == 2) load = 1'b0;
            i++;
        end
    endtask

    task automatic test_disable_reset();
        int i;
        push_frame(16'h4321, 4'b0100);
        repeat (DIV + 1) void'(expq.pop_back());
        push_idle(4);
        push_frame(16'h0000, 4'b0000);
        i = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            exp_v = expq.pop_front(); tests++;
            if (obs() !== exp_v) begin
                failed++;
                $display("FAIL disable_reset cyc=%0d got=%b want=%b", i, obs(), exp_v);
            end
            if (i == 7) enable = 1'b0;
            if (i == 8) begin rst = 1'b1; load = 1'b1; data_in = 16'hFFFF; end
            if (i == 9) begin rst = 1'b0; load = 1'b0; end
            if (i == 10) begin enable = 1'b1; blank_mask = 4'b0000; end
            i++;
        end
    endtask

    task automatic test_idle_load();
        int i;
        enable = 1'b0;
        push_idle(4);
        push_frame(16'h1234, 4'b0000);
        i = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            exp_v = expq.pop_front(); tests++;
            if (obs() !== exp_v) begin
                failed++;
                $display("FAIL idle_load cyc=%0d got=%b want=%b", i, obs(), exp_v);
            end
            if (i == 0) begin load = 1'b1; data_in = 16'h1234; end
            if (i == 1) load = 1'b0;
            if (i == 2) enable = 1'b1;
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe();
        test_lz();
        test_blank_mask();
        test_disable_reset();
        test_idle_load();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
